// File: rtl/mux_arb_pkg.sv
// Shared constants and types for the round-robin source arbiter and its picker.
package mux_arb_pkg;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int CNT_W  = 16;

    typedef logic [CH_W-1:0] ch_idx_t;
endpackage

// File: rtl/mux4.sv
// Generic 4:1 data select used by the mux stage.
module mux4 #(
    parameter int W = 8
) (
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    input  logic [1:0]   sel,
    output logic [W-1:0] y
);
    always_comb begin
        unique case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end
endmodule

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: first requester at or after ptr wins.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  ch_idx_t           ptr,
    output ch_idx_t           gnt_idx,
    output logic              gnt_any
);
    ch_idx_t idx;

    always_comb begin
        idx     = '0;
        gnt_idx = ptr;
        gnt_any = |req;
        // Walk from lowest priority to highest so the last hit is the winner.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = ptr + ch_idx_t'(k);
            if (req[idx]) gnt_idx = idx;
        end
    end
endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin 4-channel arbiter feeding a one-entry registered output stage.
// Define RR_MUX_ARB_STATS_EN to add saturating per-channel grant counters (grant_cnt).
module rr_mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CH-1:0]             in_valid,
    output logic [NUM_CH-1:0]             in_ready,
    input  logic [WIDTH-1:0]              D0,
    input  logic [WIDTH-1:0]              D1,
    input  logic [WIDTH-1:0]              D2,
    input  logic [WIDTH-1:0]              D3,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [CH_W-1:0]               out_ch
`ifdef RR_MUX_ARB_STATS_EN
    ,
    output logic [NUM_CH-1:0][CNT_W-1:0]  grant_cnt
`endif
);
    ch_idx_t          ptr;
    ch_idx_t          gnt_idx;
    logic             gnt_any;
    logic             can_load;
    logic             accept;
    logic [WIDTH-1:0] sel_data;

    rr_pick4 u_pick (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    mux4 #(.W(WIDTH)) u_mux (
        .d0  (D0),
        .d1  (D1),
        .d2  (D2),
        .d3  (D3),
        .sel (gnt_idx),
        .y   (sel_data)
    );

    assign can_load = !out_valid || out_ready;
    assign accept   = can_load && gnt_any;

    // Gate with rst_n so no producer sees a handshake while reset is held.
    always_comb begin
        in_ready = '0;
        if (accept && rst_n) in_ready[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_ch    <= gnt_idx;
            ptr       <= gnt_idx + ch_idx_t'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef RR_MUX_ARB_STATS_EN
    for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                grant_cnt[i] <= '0;
            else if (accept && gnt_idx == ch_idx_t'(i) && grant_cnt[i] != '1)
                grant_cnt[i] <= grant_cnt[i] + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: rotation, back-pressure, fairness, async reset.
module tb_rr_mux_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_valid;
    logic [3:0] in_ready;
    logic [7:0] D0, D1, D2, D3;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] out_ch;
`ifdef RR_MUX_ARB_STATS_EN
    logic [3:0][15:0] grant_cnt;
`endif

    int checks = 0;
    int failures = 0;

    rr_mux_arbiter #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .D0        (D0),
        .D1        (D1),
        .D2        (D2),
        .D3        (D3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch)
`ifdef RR_MUX_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 4'hF; out_ready = 1'b1;
        D0 = 8'h10; D1 = 8'h20; D2 = 8'h30; D3 = 8'h40;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            failures++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready);
        end
        edge1(); edge1();
        in_valid = 4'h0;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            edge1();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 4'b0000 || out_data !== 8'h00 || out_ch !== 2'd0) begin
                failures++;
                $display("FAIL idle_c%0d got v=%b rdy=%b d=%h ch=%0d exp v=0 rdy=0000 d=00 ch=0",
                         c, out_valid, in_ready, out_data, out_ch);
            end
        end
    endtask

    task automatic test_rr_stream();
        logic [1:0] exp_ch [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [7:0] exp_d  [5] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h10};
        in_valid = 4'hF; out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (in_ready !== (4'b0001 << exp_ch[c])) begin
                failures++; $display("FAIL rr_ready_c%0d got=%b exp_ch=%0d", c, in_ready, exp_ch[c]);
            end
            edge1();
            checks++;
            if (out_valid !== 1'b1 || out_ch !== exp_ch[c] || out_data !== exp_d[c]) begin
                failures++;
                $display("FAIL rr_beat_c%0d got v=%b ch=%0d d=%h exp v=1 ch=%0d d=%h",
                         c, out_valid, out_ch, out_data, exp_ch[c], exp_d[c]);
            end
        end
        in_valid = 4'h0;
        edge1();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h10 || out_ch !== 2'd0) begin
            failures++; $display("FAIL rr_drain got v=%b d=%h ch=%0d exp v=0 d=10 ch=0", out_valid, out_data, out_ch);
        end
    endtask

    task automatic test_backpressure();
        // ptr is 1 here; ch2 loads, ptr -> 3.
        D2 = 8'hA5; in_valid = 4'b0100; out_ready = 1'b1;
        edge1();
        out_ready = 1'b0; in_valid = 4'b0101;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (in_ready !== 4'b0000) begin
                failures++; $display("FAIL bp_ready_c%0d got=%b exp=0000", c, in_ready);
            end
            edge1();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd2) begin
                failures++;
                $display("FAIL bp_hold_c%0d got v=%b d=%h ch=%0d exp v=1 d=a5 ch=2", c, out_valid, out_data, out_ch);
            end
        end
        // From ptr=3, ch0 beats ch2; it replaces the held beat on the same edge.
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            failures++; $display("FAIL bp_release_ready got=%b exp=0001", in_ready);
        end
        edge1();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h10 || out_ch !== 2'd0) begin
            failures++; $display("FAIL bp_refill got v=%b d=%h ch=%0d exp v=1 d=10 ch=0", out_valid, out_data, out_ch);
        end
        in_valid = 4'h0;
        edge1();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL bp_drain got v=%b exp v=0", out_valid);
        end
    endtask

    task automatic test_fairness();
        logic [1:0] exp_ch [3] = '{2'd1, 2'd3, 2'd1};
        logic [7:0] exp_d  [3] = '{8'h20, 8'h40, 8'h20};
        out_ready = 1'b1; in_valid = 4'b1000;
        edge1();
        checks++;
        if (out_ch !== 2'd3 || out_valid !== 1'b1) begin
            failures++; $display("FAIL fair_ch3 got ch=%0d v=%b exp ch=3 v=1", out_ch, out_valid);
        end
        in_valid = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            edge1();
            checks++;
            if (out_ch !== exp_ch[c] || out_data !== exp_d[c]) begin
                failures++;
                $display("FAIL fair_c%0d got ch=%0d d=%h exp ch=%0d d=%h", c, out_ch, out_data, exp_ch[c], exp_d[c]);
            end
        end
    endtask

    task automatic test_async_reset();
        in_valid = 4'hF; out_ready = 1'b0;
        edge1();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0 || in_ready !== 4'b0000) begin
            failures++;
            $display("FAIL async_rst got v=%b d=%h ch=%0d rdy=%b exp v=0 d=00 ch=0 rdy=0000",
                     out_valid, out_data, out_ch, in_ready);
        end
        #10;
        rst_n = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            failures++; $display("FAIL post_rst_ready got=%b exp=0001", in_ready);
        end
        edge1();
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h10) begin
            failures++; $display("FAIL post_rst_beat got v=%b ch=%0d d=%h exp v=1 ch=0 d=10", out_valid, out_ch, out_data);
        end
    endtask

`ifdef RR_MUX_ARB_STATS_EN
    task automatic test_stats();
        // One ch0 accept already happened after the last reset.
        in_valid = 4'b0001; out_ready = 1'b1;
        for (int c = 0; c < 70000; c++) @(posedge clk);
        #1;
        checks++;
        if (grant_cnt[0] !== 16'hFFFF || grant_cnt[1] !== 16'h0 || grant_cnt[2] !== 16'h0 || grant_cnt[3] !== 16'h0) begin
            failures++;
            $display("FAIL stats_sat got %h %h %h %h exp ffff 0000 0000 0000",
                     grant_cnt[0], grant_cnt[1], grant_cnt[2], grant_cnt[3]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_rr_stream();
        test_backpressure();
        test_fairness();
        test_async_reset();
`ifdef RR_MUX_ARB_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
